// File: rtl/obi_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid bus: grants requests, backs them with a
// word-addressed RAM and returns in-order responses after a fixed minimum latency.
module obi_mem_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter logic [31:0] ERR_BASE        = 32'hFFFF_0000,
  parameter logic [31:0] ERR_MASK        = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_gnt_i,
  input  logic        stall_rsp_i
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int LW = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  localparam logic [LW-1:0] LAT_INIT = LW'(RESP_LATENCY - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);

  logic [31:0]                r_mem    [MEM_WORDS];
  logic [31:0]                r_q_data [MAX_OUTSTANDING];
  logic [LW-1:0]              r_q_lat  [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_q_err;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [CW-1:0]              r_count;
  logic                       r_rvalid;
  logic [31:0]                r_rdata;
  logic                       r_err;

  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_rd_word;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_idx     = addr_i[AW+1:2];
  assign w_err     = ((addr_i & ERR_MASK) == (ERR_BASE & ERR_MASK));
  assign w_rd_word = r_mem[w_idx];

  // A full queue blocks the grant even when the head pops this cycle.
  assign gnt_o  = req_i & ~stall_gnt_i & ~reset & (r_count < CNT_MAX);
  assign w_push = req_i & gnt_o;
  assign w_pop  = (r_count != '0) & (r_q_lat[r_rptr] == '0) & ~stall_rsp_i;

  always_ff @(posedge clock) begin
    if (w_push && we_i && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_q_lat[i] <= '0;
    end else begin
      // Read data is captured at the handshake edge, so a read right after a
      // write to the same word sees the freshly written value.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_push && r_wptr == PW'(i)) begin
          r_q_lat[i]  <= LAT_INIT;
          r_q_data[i] <= (we_i || w_err) ? '0 : w_rd_word;
          r_q_err[i]  <= w_err;
        end else if (r_q_lat[i] != '0) begin
          r_q_lat[i] <= r_q_lat[i] - LW'(1);
        end
      end
      if (w_push) r_wptr <= f_next(r_wptr);
      if (w_pop)  r_rptr <= f_next(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_q_data[r_rptr];
        r_err    <= r_q_err[r_rptr];
      end else begin
        r_rvalid <= 1'b0;
        r_err    <= 1'b0;
      end
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench: stimulus pushes hand-computed responses on each handshake,
// per-instance monitors pop and compare on every rvalid.
`timescale 1ns/1ps
module tb_obi_mem_responder;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk, rst;
  int   n_tests, n_fail;

  // Instance A: latency 1
  logic        a_req, a_gnt, a_we, a_rv, a_err, a_sg, a_sr;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wdata, a_rd;
  // Instance B: latency 3
  logic        b_req, b_gnt, b_we, b_rv, b_err, b_sg, b_sr;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wdata, b_rd;

  logic [31:0] exp_a_d, exp_b_d;
  logic        exp_a_e, exp_b_e;
  logic        hs_a, hs_b, prev_sr_a;
  exp_t        q_a[$], q_b[$];
  exp_t        ea, eb;
  int          n_gnt_a, n_rsp_a;
  logic [7:0]  gpat, rpat;

  obi_mem_responder #(.RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_a (
    .clock(clk), .reset(rst), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
    .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rv), .rdata_o(a_rd),
    .err_o(a_err), .stall_gnt_i(a_sg), .stall_rsp_i(a_sr));

  obi_mem_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_b (
    .clock(clk), .reset(rst), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr),
    .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata), .rvalid_o(b_rv), .rdata_o(b_rd),
    .err_o(b_err), .stall_gnt_i(b_sg), .stall_rsp_i(b_sr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Handshake is decided by the stable inputs seen at the negedge.
  always @(negedge clk) begin
    hs_a <= a_req & a_gnt;
    hs_b <= b_req & b_gnt;
  end

  always @(posedge clk) begin
    prev_sr_a <= a_sr;
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (hs_a) begin
        q_a.push_back('{d: exp_a_d, e: exp_a_e});
        n_gnt_a++;
      end
      if (hs_b) q_b.push_back('{d: exp_b_d, e: exp_b_e});
    end
  end

  always @(negedge clk) begin
    if (!rst && a_rv) begin
      n_rsp_a++;
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        ea = q_a.pop_front();
        chk("a_rdata", a_rd, ea.d);
        chkb("a_err", a_err, ea.e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rv) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_rvalid: got rvalid=1 expected no response");
      end else begin
        eb = q_b.pop_front();
        chk("b_rdata", b_rd, eb.d);
        chkb("b_err", b_err, eb.e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    logic got;
    a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
    exp_a_d = ed; exp_a_e = ee; a_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = a_gnt;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL a_gnt_timeout: got no grant expected grant within 20 cycles");
    end
    @(posedge clk);
    #1 a_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    logic g, got;
    int   g0, r0, idx;
    n_tests = 0; n_fail = 0; n_gnt_a = 0; n_rsp_a = 0;
    gpat = 8'b0011_0011;
    rpat = 8'b0011_0000;
    rst = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_be = 4'h0; a_addr = '0; a_wdata = '0; a_sg = 1'b0; a_sr = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = '0; b_wdata = '0; b_sg = 1'b0; b_sr = 1'b0;
    exp_a_d = '0; exp_a_e = 1'b0; exp_b_d = '0; exp_b_e = 1'b0;

    // Reset state; grant suppressed by reset even with req high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_gnt", a_gnt, 1'b0);
    chkb("rst_rvalid", a_rv, 1'b0);
    chk("rst_rdata", a_rd, 32'h0);
    chkb("rst_err", a_err, 1'b0);
    chkb("rst_b_rvalid", b_rv, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0; a_req = 1'b0;

    // Write then read at latency 1
    req_a(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
    req_a(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chkb("lat1_rvalid", a_rv, 1'b1);
    chk("lat1_rdata", a_rd, 32'hDEADBEEF);
    @(negedge clk);
    chkb("idle_rvalid", a_rv, 1'b0);
    chk("rdata_hold", a_rd, 32'hDEADBEEF);
    idle(1);

    // Byte enables
    req_a(1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b0);
    req_a(1'b1, 32'h20, 4'b0101, 32'h11223344, 32'h0, 1'b0);
    req_a(1'b0, 32'h20, 4'hF, 32'h0, 32'hFF22FF44, 1'b0);

    // Error window, suppressed write, aliasing, be=0
    req_a(1'b1, 32'h4, 4'hF, 32'h12345678, 32'h0, 1'b0);
    req_a(1'b0, 32'hFFFF0004, 4'hF, 32'h0, 32'h0, 1'b1);
    req_a(1'b1, 32'hFFFF0004, 4'hF, 32'hCAFEF00D, 32'h0, 1'b1);
    req_a(1'b0, 32'h1004, 4'hF, 32'h0, 32'h12345678, 1'b0);
    req_a(1'b1, 32'h10, 4'h0, 32'h0, 32'h0, 1'b0);
    req_a(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    idle(4);

    // Alternating stalls under continuous req
    g0 = n_gnt_a; r0 = n_rsp_a;
    a_we = 1'b0; a_addr = 32'h10; exp_a_d = 32'hDEADBEEF; exp_a_e = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_sg = (k % 2 == 1);
      a_sr = !a_sg;
      a_req = 1'b1;
      @(negedge clk);
      if (a_sg) chkb("stall_gnt", a_gnt, 1'b0);
      if (prev_sr_a) chkb("stall_rsp", a_rv, 1'b0);
      @(posedge clk);
      #1;
    end
    a_req = 1'b0; a_sg = 1'b0; a_sr = 1'b0;
    idle(4);
    chk("stall_grants", 32'(n_gnt_a - g0), 32'd8);
    chk("stall_responses", 32'(n_rsp_a - r0), 32'd8);

    // Reset with two responses pending
    a_sr = 1'b1;
    req_a(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    req_a(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0);
    a_req = 1'b1;
    @(negedge clk);
    chkb("full_blocks_gnt", a_gnt, 1'b0);
    @(posedge clk);
    #1 a_req = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; a_sr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chkb("post_rst_rvalid", a_rv, 1'b0);
    end
    @(posedge clk);
    #1;
    a_we = 1'b0; a_addr = 32'h10; exp_a_d = 32'hDEADBEEF; exp_a_e = 1'b0; a_req = 1'b1;
    @(negedge clk);
    chkb("gnt_after_rst", a_gnt, 1'b1);
    @(posedge clk);
    #1 a_req = 1'b0;
    idle(4);

    // Latency 3: prefill, then held req
    for (int i = 0; i < 4; i++) begin
      b_we = 1'b1; b_addr = 32'h40 + 32'(4 * i); b_be = 4'hF; b_wdata = 32'hA0 + 32'(i);
      exp_b_d = 32'h0; exp_b_e = 1'b0; b_req = 1'b1;
      got = 1'b0;
      for (int j = 0; j < 20 && !got; j++) begin
        @(negedge clk);
        got = b_gnt;
      end
      if (!got) begin
        n_tests++; n_fail++;
        $display("FAIL b_gnt_timeout: got no grant expected grant within 20 cycles");
      end
      @(posedge clk);
      #1 b_req = 1'b0;
    end
    idle(8);
    idx = 0;
    b_we = 1'b0; b_addr = 32'h40; exp_b_d = 32'hA0; exp_b_e = 1'b0; b_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chkb("lat3_gnt_pattern", b_gnt, gpat[c]);
      chkb("lat3_rvalid_pattern", b_rv, rpat[c]);
      g = b_gnt;
      @(posedge clk);
      #1;
      if (g) begin
        idx++;
        b_addr = 32'h40 + 32'(4 * idx);
        exp_b_d = 32'hA0 + 32'(idx);
      end
    end
    b_req = 1'b0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
